// File: rtl/bus_pkg.sv
// Shared select-code definitions for the bus source multiplexer.
// Codes above ACC_SEL are idle: no source is driven onto the bus.
package bus_pkg;

    typedef logic [3:0] sel_t;

    localparam sel_t DATAMEM_SEL = 4'd0;
    localparam sel_t R_SEL       = 4'd1;
    localparam sel_t IR_SEL      = 4'd2;
    localparam sel_t RL_SEL      = 4'd3;
    localparam sel_t RC_SEL      = 4'd4;
    localparam sel_t RP_SEL      = 4'd5;
    localparam sel_t RQ_SEL      = 4'd6;
    localparam sel_t R1_SEL      = 4'd7;
    localparam sel_t ACC_SEL     = 4'd8;

endpackage

// File: rtl/bus_src_mux.sv
// Combinational source decode for the bus: picks the next bus value and its valid flag.
// IR is zero-extended into the upper bits; INS_WIDTH must not exceed MEM_WIDTH.
module bus_src_mux
    import bus_pkg::*;
#(
    parameter int MEM_WIDTH = 12,
    parameter int INS_WIDTH = 8
) (
    input  sel_t                 selectIn,
    input  logic [MEM_WIDTH-1:0] DataMem,
    input  logic [MEM_WIDTH-1:0] R,
    input  logic [INS_WIDTH-1:0] IR,
    input  logic [MEM_WIDTH-1:0] RL,
    input  logic [MEM_WIDTH-1:0] RC,
    input  logic [MEM_WIDTH-1:0] RP,
    input  logic [MEM_WIDTH-1:0] RQ,
    input  logic [MEM_WIDTH-1:0] R1,
    input  logic [MEM_WIDTH-1:0] ACC,
    output logic [MEM_WIDTH-1:0] o_next,
    output logic                 o_valid
);

    logic [MEM_WIDTH-1:0] w_irExt;

    assign w_irExt = MEM_WIDTH'(IR);

    // Unknown or out-of-range codes fall through to the idle default.
    always_comb begin
        o_next  = '0;
        o_valid = 1'b1;
        case (selectIn)
            DATAMEM_SEL: o_next = DataMem;
            R_SEL:       o_next = R;
            IR_SEL:      o_next = w_irExt;
            RL_SEL:      o_next = RL;
            RC_SEL:      o_next = RC;
            RP_SEL:      o_next = RP;
            RQ_SEL:      o_next = RQ;
            R1_SEL:      o_next = R1;
            ACC_SEL:     o_next = ACC;
            default: begin
                o_next  = '0;
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus.sv
// Registered system bus: one-cycle latency from select/source sampling to busOut.
// Define BUS_IDLE_HOLD_EN to keep the last bus value on idle codes instead of zero.
module bus
    import bus_pkg::*;
#(
    parameter int MEM_WIDTH = 12,
    parameter int INS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           selectIn,
    input  logic [MEM_WIDTH-1:0] DataMem,
    input  logic [MEM_WIDTH-1:0] R,
    input  logic [INS_WIDTH-1:0] IR,
    input  logic [MEM_WIDTH-1:0] RL,
    input  logic [MEM_WIDTH-1:0] RC,
    input  logic [MEM_WIDTH-1:0] RP,
    input  logic [MEM_WIDTH-1:0] RQ,
    input  logic [MEM_WIDTH-1:0] R1,
    input  logic [MEM_WIDTH-1:0] ACC,
    output logic [MEM_WIDTH-1:0] busOut,
    output logic                 busValid
);

    logic [MEM_WIDTH-1:0] w_next;
    logic                 w_valid;
    logic [MEM_WIDTH-1:0] r_busOut;
    logic                 r_busValid;

    bus_src_mux #(
        .MEM_WIDTH(MEM_WIDTH),
        .INS_WIDTH(INS_WIDTH)
    ) u_srcMux (
        .selectIn(selectIn),
        .DataMem (DataMem),
        .R       (R),
        .IR      (IR),
        .RL      (RL),
        .RC      (RC),
        .RP      (RP),
        .RQ      (RQ),
        .R1      (R1),
        .ACC     (ACC),
        .o_next  (w_next),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busOut   <= '0;
            r_busValid <= 1'b0;
        end else begin
            r_busValid <= w_valid;
`ifdef BUS_IDLE_HOLD_EN
            if (w_valid) begin
                r_busOut <= w_next;
            end
`else
            r_busOut <= w_next;
`endif
        end
    end

    assign busOut   = r_busOut;
    assign busValid = r_busValid;

endmodule

// File: tb/tb_bus.sv
// Self-checking bench for bus: directed vector table, hand sequences and a random run
// checked against an array-indexed reference model of the source selection.
`timescale 1ns/1ps
module tb_bus;

    localparam int MW = 12;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    selectIn = 4'd0;
    logic [MW-1:0] DataMem = '0, R = '0, RL = '0, RC = '0, RP = '0, RQ = '0, R1 = '0, ACC = '0;
    logic [IW-1:0] IR = '0;
    logic [MW-1:0] busOut;
    logic          busValid;

    int nCompared = 0;
    int nMismatched = 0;

    bus #(.MEM_WIDTH(MW), .INS_WIDTH(IW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .selectIn(selectIn),
        .DataMem (DataMem),
        .R       (R),
        .IR      (IR),
        .RL      (RL),
        .RC      (RC),
        .RP      (RP),
        .RQ      (RQ),
        .R1      (R1),
        .ACC     (ACC),
        .busOut  (busOut),
        .busValid(busValid)
    );

    always #5 clk = ~clk;

`ifdef BUS_IDLE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        string         name;
        logic          rstN;
        logic [3:0]    sel;
        logic [MW-1:0] expOut;
        logic          expValid;
    } vec_t;

    vec_t vecs[$];
    logic [MW-1:0] modelOut;

    // Drive one cycle of control inputs, then sample just after the capturing edge.
    task automatic applyStimulus(input logic rstN, input logic [3:0] sel);
        rst_n    = rstN;
        selectIn = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [MW-1:0] expOut, input logic expValid);
        nCompared++;
        if (busOut !== expOut || busValid !== expValid) begin
            nMismatched++;
            $display("[TB] FAIL %s: got busOut=%h busValid=%b, expected busOut=%h busValid=%b",
                     name, busOut, busValid, expOut, expValid);
        end
    endtask

    // Reference: the selectable sources as an array indexed by select code.
    function automatic void refStep(input logic rstN, input logic [3:0] sel,
                                    output logic [MW-1:0] expOut, output logic expValid);
        logic [MW-1:0] src [0:8];
        src[0] = DataMem; src[1] = R;  src[2] = {{(MW-IW){1'b0}}, IR};
        src[3] = RL;      src[4] = RC; src[5] = RP; src[6] = RQ; src[7] = R1; src[8] = ACC;
        if (!rstN) begin
            expOut = '0; expValid = 1'b0;
        end else if (int'(sel) <= 8) begin
            expOut = src[sel]; expValid = 1'b1;
        end else begin
            expOut = HOLD ? modelOut : '0; expValid = 1'b0;
        end
        modelOut = expOut;
    endfunction

    initial begin
        logic [MW-1:0] idleAfterAcc;
        logic [MW-1:0] eOut;
        logic          eVal;
        logic          rr;
        logic [3:0]    ss;

        idleAfterAcc = HOLD ? 12'h987 : 12'h000;
        DataMem = 12'h123; R = 12'h456; RL = 12'h789; RC = 12'hABC; RP = 12'hDEF;
        RQ = 12'hF00; R1 = 12'hFED; ACC = 12'h987; IR = 8'hAA;

        vecs.push_back('{"reset0",  1'b0, 4'h0, 12'h000, 1'b0});
        vecs.push_back('{"reset1",  1'b0, 4'h0, 12'h000, 1'b0});
        vecs.push_back('{"selMem",  1'b1, 4'h0, 12'h123, 1'b1});
        vecs.push_back('{"selR",    1'b1, 4'h1, 12'h456, 1'b1});
        vecs.push_back('{"selIR",   1'b1, 4'h2, 12'h0AA, 1'b1});
        vecs.push_back('{"selRL",   1'b1, 4'h3, 12'h789, 1'b1});
        vecs.push_back('{"selRC",   1'b1, 4'h4, 12'hABC, 1'b1});
        vecs.push_back('{"selRP",   1'b1, 4'h5, 12'hDEF, 1'b1});
        vecs.push_back('{"selRQ",   1'b1, 4'h6, 12'hF00, 1'b1});
        vecs.push_back('{"selR1",   1'b1, 4'h7, 12'hFED, 1'b1});
        vecs.push_back('{"selACC",  1'b1, 4'h8, 12'h987, 1'b1});
        vecs.push_back('{"idle9",   1'b1, 4'h9, idleAfterAcc, 1'b0});
        vecs.push_back('{"idleA",   1'b1, 4'hA, idleAfterAcc, 1'b0});
        vecs.push_back('{"idleB",   1'b1, 4'hB, idleAfterAcc, 1'b0});
        vecs.push_back('{"idleC",   1'b1, 4'hC, idleAfterAcc, 1'b0});
        vecs.push_back('{"idleD",   1'b1, 4'hD, idleAfterAcc, 1'b0});
        vecs.push_back('{"idleE",   1'b1, 4'hE, idleAfterAcc, 1'b0});
        vecs.push_back('{"idleF",   1'b1, 4'hF, idleAfterAcc, 1'b0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].sel);
            checkOutput(vecs[i].name, vecs[i].expOut, vecs[i].expValid);
        end

        // Latency: R changes while selected; new value appears on the very next edge.
        applyStimulus(1'b1, 4'h1);
        checkOutput("latR456", 12'h456, 1'b1);
        R = 12'h111;
        applyStimulus(1'b1, 4'h1);
        checkOutput("latR111", 12'h111, 1'b1);

        // Mid-stream reset while ACC is selected.
        applyStimulus(1'b1, 4'h8);
        checkOutput("midPre", 12'h987, 1'b1);
        applyStimulus(1'b0, 4'h8);
        checkOutput("midRst", 12'h000, 1'b0);
        applyStimulus(1'b1, 4'h8);
        checkOutput("midPost", 12'h987, 1'b1);

        // Idle after a non-zero IR selection checks the hold/zero path once more.
        applyStimulus(1'b1, 4'h2);
        checkOutput("irAgain", 12'h0AA, 1'b1);
        applyStimulus(1'b1, 4'hC);
        checkOutput("idleAfterIR", HOLD ? 12'h0AA : 12'h000, 1'b0);

        // Random run against the reference model, starting from a known reset.
        modelOut = '0;
        applyStimulus(1'b0, 4'h0);
        refStep(1'b0, 4'h0, eOut, eVal);
        checkOutput("rndReset", eOut, eVal);
        for (int n = 0; n < 300; n++) begin
            DataMem = MW'($urandom); R  = MW'($urandom); RL = MW'($urandom);
            RC = MW'($urandom); RP = MW'($urandom); RQ = MW'($urandom);
            R1 = MW'($urandom); ACC = MW'($urandom); IR = IW'($urandom);
            rr = ($urandom_range(0, 15) != 0);
            ss = 4'($urandom_range(0, 15));
            refStep(rr, ss, eOut, eVal);
            applyStimulus(rr, ss);
            checkOutput($sformatf("rnd%0d_sel%h", n, ss), eOut, eVal);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
